// File: rtl/piso_shift_register.sv
// piso_shift_register: MSB-first parallel-in serial-out shifter; define PISO_BITCNT_EN for a busy flag that freezes on word[0]
module piso_shift_register #(
  parameter int   WIDTH    = 10,
  parameter logic FILL_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_n,
`ifdef PISO_BITCNT_EN
  output logic             busy,
`endif
  output logic             data_out
);
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shifted;
  assign shifted  = (shift_reg << 1) | WIDTH'(FILL_BIT);
  assign data_out = shift_reg[WIDTH-1];
`ifdef PISO_BITCNT_EN
  localparam int CW = $clog2(WIDTH + 1);
  logic [CW-1:0] cnt;
  assign busy = (cnt != '0);
  always_ff @(posedge clk)
    if (!reset) begin
      shift_reg <= '0;
      cnt       <= '0;
    end else if (!load_n) begin
      shift_reg <= data_in;
      cnt       <= CW'(WIDTH - 1);
    end else if (busy) begin
      shift_reg <= shifted;
      cnt       <= cnt - 1'b1;
    end
`else
  always_ff @(posedge clk)
    if (!reset) shift_reg <= '0;
    else if (!load_n) shift_reg <= data_in;
    else shift_reg <= shifted;
`endif
endmodule

// File: tb/tb_piso_shift_register.sv
// tb_piso_shift_register: directed and random checks of the PISO against a word/shift-count model
module tb_piso_shift_register;
  localparam int   W    = 10;
  localparam logic FILL = 1'b0;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         load_n = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [3:0]   d4 = '0;
  logic         data_out, data_out4;
  logic         busy, busy4;
  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] m_word = '0;
  int           m_k = W;
  logic [11:0]  exp2;
  logic [4:0]   exp6;
  always #5 clk = ~clk;
`ifdef PISO_BITCNT_EN
  piso_shift_register #(.WIDTH(W), .FILL_BIT(FILL)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .load_n(load_n), .busy(busy), .data_out(data_out));
  piso_shift_register #(.WIDTH(4), .FILL_BIT(1'b0)) dut4 (
    .clk(clk), .reset(reset), .data_in(d4), .load_n(load_n), .busy(busy4), .data_out(data_out4));
`else
  assign busy  = 1'b0;
  assign busy4 = 1'b0;
  piso_shift_register #(.WIDTH(W), .FILL_BIT(FILL)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .load_n(load_n), .data_out(data_out));
  piso_shift_register #(.WIDTH(4), .FILL_BIT(1'b0)) dut4 (
    .clk(clk), .reset(reset), .data_in(d4), .load_n(load_n), .data_out(data_out4));
`endif
  function automatic logic exp_bit();
    int idx = W - 1 - m_k;
    if (idx >= 0) return m_word[idx];
`ifdef PISO_BITCNT_EN
    return m_word[0];
`else
    return FILL;
`endif
  endfunction
  task automatic chk(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, expv, $time);
    end
  endtask
  task automatic step(input logic r, input logic ld, input logic [W-1:0] d);
    @(negedge clk);
    reset = r;
    load_n = ld;
    data_in = d;
    @(posedge clk);
    if (!r) begin
      m_word = '0;
      m_k = W;
    end else if (!ld) begin
      m_word = d;
      m_k = 0;
    end else m_k++;
    #1;
    chk("data_out", data_out, exp_bit());
`ifdef PISO_BITCNT_EN
    chk("busy", busy, m_k < W - 1);
`endif
  endtask
  initial begin
    // 1: reset overrides load
    step(1'b0, 1'b0, 10'h3FF);
    step(1'b0, 1'b0, 10'h3FF);
    chk("reset_out", data_out, 1'b0);
    // 2: load and shift 12 edges, also compared against the literal sequence
`ifdef PISO_BITCNT_EN
    exp2 = 12'b010010111111;
`else
    exp2 = 12'b010010111100;
`endif
    step(1'b1, 1'b0, 10'b0100101111);
    chk("seq_0", data_out, exp2[11]);
    for (int i = 1; i < 12; i++) begin
      step(1'b1, 1'b1, '0);
      chk($sformatf("seq_%0d", i), data_out, exp2[11-i]);
`ifdef PISO_BITCNT_EN
      chk($sformatf("busy_%0d", i), busy, i < 9);
`endif
    end
    // 3: held load follows bit 9
    step(1'b1, 1'b0, 10'h200);
    chk("held_1", data_out, 1'b1);
    step(1'b1, 1'b0, 10'h000);
    chk("held_0", data_out, 1'b0);
    // 4: reload mid-word
    step(1'b1, 1'b0, 10'h3FF);
    repeat (3) step(1'b1, 1'b1, '0);
    step(1'b1, 1'b0, 10'h000);
    chk("reload", data_out, 1'b0);
    // 5: reset mid-word discards remaining bits
    step(1'b1, 1'b0, 10'h3FF);
    repeat (2) step(1'b1, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    chk("mid_reset", data_out, 1'b0);
    repeat (3) begin
      step(1'b1, 1'b1, '0);
      chk("post_reset", data_out, 1'b0);
    end
    // 6: WIDTH=4 instance
    exp6 = 5'b10100;
    d4 = 4'b1010;
    step(1'b1, 1'b0, '0);
    chk("w4_0", data_out4, exp6[4]);
    for (int i = 1; i < 5; i++) begin
      step(1'b1, 1'b1, '0);
      chk($sformatf("w4_%0d", i), data_out4, exp6[4-i]);
    end
    // random traffic, mostly shifts with occasional loads and rare resets
    for (int i = 0; i < 400; i++) begin
      logic r, ld;
      r  = ($urandom_range(0, 39) != 0);
      ld = ($urandom_range(0, 6) != 0);
      step(r, ld, W'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
